bus_arb_ctrl: RTL and testbench

BUS_ARB_CTRL -- requirements
Module: bus_arb_ctrl

---
 rtl/bus_arb_ctrl_if.sv | 24 ++
 rtl/bus_arb_ctrl.sv | 133 +++++++++++++
 tb/tb_bus_arb_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arb_ctrl_if.sv
// rtl/bus_arb_ctrl_if.sv - shared slave bus between the arbiter (master) and the bus slave
interface bus_arb_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] BUS_addr;
    logic [DATA_WIDTH-1:0] BUS_wdata;
    logic                  BUS_mode;
    logic                  BUS_valid;
    logic                  BUS_wready;
    logic [DATA_WIDTH-1:0] BUS_rdata;
    logic                  BUS_rvalid;
    logic                  BUS_rready;

    modport master (
        output BUS_addr, BUS_wdata, BUS_mode, BUS_valid, BUS_rready,
        input  BUS_wready, BUS_rdata, BUS_rvalid
    );

    modport slave (
        input  BUS_addr, BUS_wdata, BUS_mode, BUS_valid, BUS_rready,
        output BUS_wready, BUS_rdata, BUS_rvalid
    );
endinterface

// File: rtl/bus_arb_ctrl.sv
// rtl/bus_arb_ctrl.sv - round-robin arbiter driving one bus transaction at a time (optional BUS_ARB_TIMEOUT_EN)
module bus_arb_ctrl #(
    parameter int NUM_CH         = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            req,
    input  logic [NUM_CH-1:0]            mode,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] wdata,
    output logic [NUM_CH-1:0]            done,
    output logic                         err,
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic [NUM_CH-1:0]            grant,
    bus_arb_ctrl_if.master               bus
);
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [IW-1:0] last;
    logic [IW-1:0] cur;
    logic [IW-1:0] sel;
    logic          complete;

`ifdef BUS_ARB_TIMEOUT_EN
    logic [15:0] tcnt;
    logic        err_r;
    logic        timed_out;

    assign err       = err_r;
    // Limit hit on this BUSY cycle; a same-cycle completion takes precedence.
    assign timed_out = (state == BUSY) && !complete && (tcnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign err = 1'b0;
`endif

    // Handshake of the opposite direction is never looked at.
    assign complete = (state == BUSY) && (bus.BUS_mode ? bus.BUS_wready : bus.BUS_rvalid);

    // Round-robin pick: first requester at or after last granted + 1.
    always_comb begin
        logic          found;
        logic [IW-1:0] c;
        found = 1'b0;
        sel   = last;
        c     = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            c = IW'((int'(last) + k) % NUM_CH);
            if (!found && req[c]) begin
                found = 1'b1;
                sel   = c;
            end
        end
    end

    // Transaction FSM with all outputs registered; done is a one-cycle pulse in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last          <= IW'(NUM_CH - 1);
            cur           <= '0;
            done          <= '0;
            grant         <= '0;
            rdata         <= '0;
            bus.BUS_addr  <= '0;
            bus.BUS_wdata <= '0;
            bus.BUS_mode  <= 1'b0;
            bus.BUS_valid <= 1'b0;
            bus.BUS_rready <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            tcnt          <= '0;
            err_r         <= 1'b0;
`endif
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state          <= BUSY;
                        cur            <= sel;
                        grant          <= NUM_CH'(1) << sel;
                        bus.BUS_addr   <= addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
                        bus.BUS_mode   <= mode[sel];
                        if (mode[sel]) begin
                            bus.BUS_wdata <= wdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
                        end
                        bus.BUS_valid  <= 1'b1;
                        bus.BUS_rready <= !mode[sel];
`ifdef BUS_ARB_TIMEOUT_EN
                        tcnt           <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (complete) begin
                        state          <= DONE;
                        bus.BUS_valid  <= 1'b0;
                        bus.BUS_rready <= 1'b0;
                        done           <= grant;
                        if (!bus.BUS_mode) begin
                            rdata <= bus.BUS_rdata;
                        end
`ifdef BUS_ARB_TIMEOUT_EN
                        err_r          <= 1'b0;
                    end else if (timed_out) begin
                        state          <= DONE;
                        bus.BUS_valid  <= 1'b0;
                        bus.BUS_rready <= 1'b0;
                        done           <= grant;
                        err_r          <= 1'b1;
                    end else begin
                        tcnt           <= tcnt + 16'd1;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                    grant <= '0;
                    last  <= cur;
`ifdef BUS_ARB_TIMEOUT_EN
                    err_r <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arb_ctrl.sv
// tb/tb_bus_arb_ctrl.sv - self-checking bench for bus_arb_ctrl (vector table, corner sequences, random vs model)
module tb_bus_arb_ctrl;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    mode;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    done;
    logic            err;
    logic [DW-1:0]   rdata;
    logic [N-1:0]    grant;

    logic [AW-1:0]   a_addr [N];
    logic [DW-1:0]   a_wdata[N];

    int              total = 0;
    int              bad   = 0;
    logic [DW-1:0]   exp_rdata;

    bus_arb_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    bus_arb_ctrl #(
        .NUM_CH(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .mode(mode), .addr(addr), .wdata(wdata),
        .done(done), .err(err), .rdata(rdata), .grant(grant), .bus(bus)
    );

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign addr [g*AW +: AW] = a_addr[g];
        assign wdata[g*DW +: DW] = a_wdata[g];
    end

    typedef struct {
        logic [N-1:0] r;
        bit           m;
        int           exp_ch;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, want);
        end
    endtask

    task automatic set_ch(input int c, input bit m, input logic [AW-1:0] a, input logic [DW-1:0] d);
        mode[c]    = m;
        a_addr[c]  = a;
        a_wdata[c] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        exp_rdata = '0;
    endtask

    // Spec rule: first requester searching from (last + 1) mod N.
    function automatic int rr_pick(input int lst, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(lst + k) % N]) return (lst + k) % N;
        end
        return -1;
    endfunction

    // Called at a negedge in IDLE with req already set; ends at a negedge back in IDLE.
    task automatic run_txn(input int ch, input int waits, input logic [DW-1:0] rval, input string tag);
        bit m;
        m = mode[ch];
        @(negedge clk);
        chk({tag, ".grant"}, grant, 4'b0001 << ch);
        chk({tag, ".valid"}, bus.BUS_valid, 1'b1);
        chk({tag, ".addr"}, bus.BUS_addr, a_addr[ch]);
        chk({tag, ".bmode"}, bus.BUS_mode, m);
        chk({tag, ".rready"}, bus.BUS_rready, !m);
        if (m) chk({tag, ".bwdata"}, bus.BUS_wdata, a_wdata[ch]);
        for (int w = 0; w < waits; w++) begin
            bus.BUS_rvalid = m;
            bus.BUS_wready = !m;
            bus.BUS_rdata  = $urandom;
            @(negedge clk);
            chk({tag, ".wait_done"}, done, '0);
            chk({tag, ".wait_valid"}, bus.BUS_valid, 1'b1);
        end
        bus.BUS_rvalid = !m;
        bus.BUS_wready = m;
        bus.BUS_rdata  = rval;
        @(negedge clk);
        if (!m) exp_rdata = rval;
        chk({tag, ".done"}, done, 4'b0001 << ch);
        chk({tag, ".err"}, err, 1'b0);
        chk({tag, ".rdata"}, rdata, exp_rdata);
        chk({tag, ".valid_off"}, bus.BUS_valid, 1'b0);
        chk({tag, ".rready_off"}, bus.BUS_rready, 1'b0);
        bus.BUS_rvalid = 1'b0;
        bus.BUS_wready = 1'b0;
        bus.BUS_rdata  = $urandom;
        @(negedge clk);
        chk({tag, ".done_end"}, done, '0);
        chk({tag, ".grant_end"}, grant, '0);
    endtask

    initial begin
        vec_t tbl[8];
        int   n;
        int   m_last;
        int   c;

        tbl[0] = '{4'b0001, 1'b1, 0};
        tbl[1] = '{4'b0001, 1'b0, 0};
        tbl[2] = '{4'b1010, 1'b1, 1};
        tbl[3] = '{4'b1010, 1'b0, 3};
        tbl[4] = '{4'b1111, 1'b1, 0};
        tbl[5] = '{4'b0100, 1'b0, 2};
        tbl[6] = '{4'b1001, 1'b1, 3};
        tbl[7] = '{4'b1110, 1'b0, 1};

        req = '0; mode = '0;
        for (int i = 0; i < N; i++) set_ch(i, 1'b0, '0, '0);
        bus.BUS_wready = 1'b0; bus.BUS_rvalid = 1'b0; bus.BUS_rdata = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.done", done, '0);
        chk("rst.err", err, 1'b0);
        chk("rst.grant", grant, '0);
        chk("rst.rdata", rdata, '0);
        chk("rst.valid", bus.BUS_valid, 1'b0);
        chk("rst.rready", bus.BUS_rready, 1'b0);
        chk("rst.baddr", bus.BUS_addr, '0);
        chk("rst.bwdata", bus.BUS_wdata, '0);
        chk("rst.bmode", bus.BUS_mode, 1'b0);
        rst_n = 1'b1; exp_rdata = '0;

        // Single write on ch0, zero wait.
        set_ch(0, 1'b1, 32'h100, 32'hDEADBEEF);
        req = 4'b0001;
        run_txn(0, 0, 32'h0, "wr1");
        req = '0;

        // ch2 read, rvalid three cycles after BUS_valid.
        set_ch(2, 1'b0, 32'h40, 32'h0);
        req = 4'b0100;
        run_txn(2, 3, 32'h12345678, "rd3");
        req = '0;

        // Stray rvalid while idle.
        bus.BUS_rvalid = 1'b1; bus.BUS_rdata = 32'hBAD0BAD0;
        repeat (3) @(negedge clk);
        chk("stray.rdata", rdata, exp_rdata);
        chk("stray.done", done, '0);
        chk("stray.valid", bus.BUS_valid, 1'b0);
        bus.BUS_rvalid = 1'b0;

        // Arbitration vector table from reset priority.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < N; k++) set_ch(k, tbl[i].m, 32'h1000 + 32'(k*16 + i), 32'hA500_0000 + 32'(k*256 + i));
            req = tbl[i].r;
            run_txn(tbl[i].exp_ch, i % 3, 32'hC0DE_0000 + 32'(i), $sformatf("tbl%0d", i));
        end
        req = '0;

        // Contention: all four requesting, served 0,1,2,3,0.
        do_reset();
        for (int k = 0; k < N; k++) set_ch(k, 1'b1, 32'h2000 + 32'(k), 32'h5000 + 32'(k));
        req = 4'b1111;
        for (int i = 0; i < 5; i++) run_txn(i % N, 0, 32'h0, $sformatf("rr%0d", i));
        req = '0;

        // Reset in the middle of a ch3 write.
        set_ch(3, 1'b1, 32'h300, 32'h33);
        req = 4'b1000;
        @(negedge clk);
        chk("mrst.grant", grant, 4'b1000);
        chk("mrst.valid", bus.BUS_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst.valid_async", bus.BUS_valid, 1'b0);
        chk("mrst.grant_async", grant, '0);
        @(negedge clk);
        chk("mrst.done", done, '0);
        rst_n = 1'b1; exp_rdata = '0;
        set_ch(0, 1'b1, 32'h10, 32'h11);
        req = 4'b1001;
        run_txn(0, 0, 32'h0, "mrst.prio");
        req = '0;

        // ch1 read with no rvalid.
        set_ch(1, 1'b0, 32'h44, 32'h0);
        req = 4'b0010;
`ifdef BUS_ARB_TIMEOUT_EN
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == '0 && n < 20);
        chk("tmo.cycles", n, 9);
        chk("tmo.done", done, 4'b0010);
        chk("tmo.err", err, 1'b1);
        chk("tmo.rdata", rdata, exp_rdata);
        @(negedge clk);
        chk("tmo.grant_end", grant, '0);
`else
        repeat (20) @(negedge clk);
        chk("notmo.valid", bus.BUS_valid, 1'b1);
        chk("notmo.done", done, '0);
        bus.BUS_rvalid = 1'b1; bus.BUS_rdata = 32'h0F0F0F0F;
        @(negedge clk);
        exp_rdata = 32'h0F0F0F0F;
        chk("notmo.fin_done", done, 4'b0010);
        chk("notmo.rdata", rdata, exp_rdata);
        bus.BUS_rvalid = 1'b0;
        @(negedge clk);
`endif
        // Completion on the eighth BUSY cycle still counts as success.
        run_txn(1, 7, 32'h7777_8888, "tmo.edge");
        req = '0;

        // Random traffic against the transaction-level model.
        do_reset();
        m_last = N - 1;
        for (int k = 0; k < N; k++) set_ch(k, 1'($urandom), $urandom, $urandom);
        req = 4'($urandom);
        for (int t = 0; t < 40; t++) begin
            if (req == '0) req[$urandom_range(0, N-1)] = 1'b1;
            c = rr_pick(m_last, req);
            run_txn(c, $urandom_range(0, 5), $urandom, $sformatf("rnd%0d", t));
            m_last = c;
            set_ch(c, 1'($urandom), $urandom, $urandom);
            req[c] = 1'($urandom);
            req    = req | (4'($urandom) & 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
